// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the strobe-qualified data synchroniser FIFO.
// Capture-mode selectors and a width helper usable in parameter/port declarations.
package data_sync_pkg;

    localparam int MODE_LEVEL = 0;
    localparam int MODE_EDGE  = 1;

    // Smallest n with 2**n >= value; constant-evaluable for port widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock show-ahead FIFO: storage, wrapping pointers and an occupancy count.
// Full/empty come from the count so pointer equality never needs disambiguation.
module sync_fifo_core
    import data_sync_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   rd,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (level == '0);
        full    = (level == LW'(DEPTH));
        do_pop  = rd & ~empty;
        // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
        do_push = wr & (~full | do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is deliberately left unreset; the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/data_sync_fifo.sv
// Bundled-data receiver: synchronises an asynchronous strobe, captures the qualified
// word into a small FIFO and presents it to the consumer with a valid/ack handshake.
module data_sync_fifo
    import data_sync_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int EDGE_MODE   = MODE_EDGE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   dready_i,
    output logic [WIDTH-1:0]       dout,
    output logic                   dready_o,
    input  logic                   dack_i,
    output logic [clog2(DEPTH):0]  level,
    output logic                   overflow
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   synced;
    logic                   wr;
    logic                   rd;
    logic                   empty;
    logic                   full;
    logic [WIDTH-1:0]       head;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dready_i};
            sync_d <= synced;
        end
    end

    always_comb begin
        if (EDGE_MODE == MODE_EDGE) begin
            wr = synced & ~sync_d;
        end else begin
            wr = synced;
        end
        rd = dack_i & ~empty;
    end

    sync_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .wdata (din),
        .rd    (rd),
        .rdata (head),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    // Sticky until reset: only a push that the core had to refuse counts as a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr & full & ~rd) begin
            overflow <= 1'b1;
        end
    end

    assign dready_o = ~empty;
    assign dout     = empty ? '0 : head;

endmodule

// File: tb/tb_data_sync_fifo.sv
// Bench for data_sync_fifo: three configurations (edge/8b/2-stage, level/8b/2-stage,
// edge/16b/3-stage) checked against directed expectations and a queue-based model.
module tb_data_sync_fifo;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din_a, din_b;
    logic [15:0] din_c;
    logic [2:0]  strb, ack;
    logic [7:0]  dout_a, dout_b;
    logic [15:0] dout_c;
    logic [2:0]  rdy, ovf;
    logic [2:0]  lvl_a, lvl_b, lvl_c;

    logic [15:0] obs_dout [3];
    logic [2:0]  obs_lvl  [3];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    data_sync_fifo #(.WIDTH(8), .SYNC_STAGES(2), .DEPTH(D), .EDGE_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .dready_i(strb[0]), .dout(dout_a),
        .dready_o(rdy[0]), .dack_i(ack[0]), .level(lvl_a), .overflow(ovf[0]));

    data_sync_fifo #(.WIDTH(8), .SYNC_STAGES(2), .DEPTH(D), .EDGE_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .dready_i(strb[1]), .dout(dout_b),
        .dready_o(rdy[1]), .dack_i(ack[1]), .level(lvl_b), .overflow(ovf[1]));

    data_sync_fifo #(.WIDTH(16), .SYNC_STAGES(3), .DEPTH(D), .EDGE_MODE(1)) dut_c (
        .clk(clk), .rst(rst), .din(din_c), .dready_i(strb[2]), .dout(dout_c),
        .dready_o(rdy[2]), .dack_i(ack[2]), .level(lvl_c), .overflow(ovf[2]));

    always_comb begin
        obs_dout[0] = {8'h00, dout_a};
        obs_dout[1] = {8'h00, dout_b};
        obs_dout[2] = dout_c;
        obs_lvl[0]  = lvl_a;
        obs_lvl[1]  = lvl_b;
        obs_lvl[2]  = lvl_c;
    end

    // Reference model: the strobe is seen N edges late; a capture is taken on that
    // delayed strobe (or its rising edge), and the FIFO is a plain queue.
    logic [15:0] mq   [3][$];
    bit          hist [3][$];
    bit          m_ovf [3];
    bit          m_sy, m_pv, m_push, m_pop;

    function automatic int stg(input int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic logic [15:0] din_of(input int k);
        if (k == 0) return {8'h00, din_a};
        if (k == 1) return {8'h00, din_b};
        return din_c;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mq[k].delete();
                hist[k].delete();
                for (int j = 0; j <= stg(k); j++) hist[k].push_back(1'b0);
                m_ovf[k] = 1'b0;
            end else begin
                m_sy   = hist[k][stg(k)-1];
                m_pv   = hist[k][stg(k)];
                m_push = (k == 1) ? m_sy : (m_sy && !m_pv);
                m_pop  = ack[k] && (mq[k].size() > 0);
                if (m_push && mq[k].size() == D && !m_pop) begin
                    m_ovf[k] = 1'b1;
                end else begin
                    if (m_pop)  void'(mq[k].pop_front());
                    if (m_push) mq[k].push_back(din_of(k));
                end
                hist[k].push_front(strb[k]);
                void'(hist[k].pop_back());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; strb = '0; ack = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; strb = '0; ack = '0; din_a = '0; din_b = '0; din_c = '0;
        wait_cycles(2);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_lvl[k] !== 3'd0 || rdy[k] !== 1'b0 || obs_dout[k] !== 16'h0 || ovf[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state dut%0d: level=%0d rdy=%b dout=%h ovf=%b, required 0/0/0/0",
                         k, obs_lvl[k], rdy[k], obs_dout[k], ovf[k]);
            end
        end
    endtask

    task automatic test_single_capture();
        din_a = 8'hA5; strb[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if (rdy[0] !== (e >= 3)) begin
                fails++;
                $display("FAIL single_latency edge %0d: dready_o=%b required %b", e, rdy[0], e >= 3);
            end
        end
        checks++;
        if (lvl_a !== 3'd1 || dout_a !== 8'hA5) begin
            fails++;
            $display("FAIL single_word: level=%0d dout=%h required 1/a5", lvl_a, dout_a);
        end
        strb[0] = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int p = 1; p <= 5; p++) begin
            din_a = 8'(p); strb[0] = 1'b1;
            wait_cycles(3);
            strb[0] = 1'b0;
            wait_cycles(3);
            checks++;
            if (lvl_a !== 3'((p > D) ? D : p) || ovf[0] !== (p > D) || dout_a !== 8'h01) begin
                fails++;
                $display("FAIL overflow_fill pulse %0d: level=%0d ovf=%b dout=%h required %0d/%b/01",
                         p, lvl_a, ovf[0], dout_a, (p > D) ? D : p, p > D);
            end
        end
    endtask

    task automatic test_drain();
        ack[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (i < 4 && (dout_a !== 8'(i + 1) || rdy[0] !== 1'b1)) begin
                fails++;
                $display("FAIL drain_seq pop %0d: dout=%h rdy=%b required %h/1", i, dout_a, rdy[0], i + 1);
            end else if (i == 4 && (dout_a !== 8'h00 || rdy[0] !== 1'b0 || lvl_a !== 3'd0)) begin
                fails++;
                $display("FAIL drain_empty: dout=%h rdy=%b level=%0d required 00/0/0", dout_a, rdy[0], lvl_a);
            end
        end
        ack[0] = 1'b0;
        wait_cycles(2);
        checks++;
        if (ovf[0] !== 1'b1 || lvl_a !== 3'd0) begin
            fails++;
            $display("FAIL drain_sticky: ovf=%b level=%0d required 1/0", ovf[0], lvl_a);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        strb[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            din_b = 8'(e);
            if (e == 7) ack[1] = 1'b1;
            @(negedge clk);
            checks++;
            if (e == 6 && (lvl_b !== 3'd4 || dout_b !== 8'd3)) begin
                fails++;
                $display("FAIL b2b_fill: level=%0d dout=%h required 4/03", lvl_b, dout_b);
            end else if (e >= 7 && (lvl_b !== 3'd4 || dout_b !== 8'(e - 3) || ovf[1] !== 1'b0)) begin
                fails++;
                $display("FAIL b2b_stream edge %0d: level=%0d dout=%h ovf=%b required 4/%h/0",
                         e, lvl_b, dout_b, ovf[1], e - 3);
            end
        end
        strb[1] = 1'b0;
        wait_cycles(10);
        ack[1] = 1'b0;
        checks++;
        if (lvl_b !== 3'd0 || ovf[1] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: level=%0d ovf=%b required 0/0", lvl_b, ovf[1]);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int p = 1; p <= 3; p++) begin
            din_a = 8'(8'h10 + p); strb[0] = 1'b1;
            wait_cycles(3);
            strb[0] = 1'b0;
            wait_cycles(3);
        end
        din_a = 8'h77; strb[0] = 1'b1;
        wait_cycles(1);
        checks++;
        if (lvl_a !== 3'd3) begin
            fails++;
            $display("FAIL midreset_pre: level=%0d required 3", lvl_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (lvl_a !== 3'd0 || rdy[0] !== 1'b0 || ovf[0] !== 1'b0 || dout_a !== 8'h00) begin
            fails++;
            $display("FAIL midreset_clear: level=%0d rdy=%b ovf=%b dout=%h required 0/0/0/00",
                     lvl_a, rdy[0], ovf[0], dout_a);
        end
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if (rdy[0] !== (e >= 3) || lvl_a !== 3'((e >= 3) ? 1 : 0)) begin
                fails++;
                $display("FAIL midreset_recapture edge %0d: rdy=%b level=%0d required %b/%0d",
                         e, rdy[0], lvl_a, e >= 3, (e >= 3) ? 1 : 0);
            end
        end
        checks++;
        if (dout_a !== 8'h77) begin
            fails++;
            $display("FAIL midreset_word: dout=%h required 77", dout_a);
        end
        strb[0] = 1'b0;
    endtask

    task automatic test_glitch_wide();
        do_reset();
        din_c = 16'hBEEF; strb[2] = 1'b1;
        @(negedge clk);
        strb[2] = 1'b0;
        for (int e = 2; e <= 6; e++) begin
            @(negedge clk);
            checks++;
            if (rdy[2] !== (e >= 4) || dout_c !== ((e >= 4) ? 16'hBEEF : 16'h0000)) begin
                fails++;
                $display("FAIL glitch_wide edge %0d: rdy=%b dout=%h required %b/%h",
                         e, rdy[2], dout_c, e >= 4, (e >= 4) ? 16'hBEEF : 16'h0000);
            end
        end
        checks++;
        if (lvl_c !== 3'd1) begin
            fails++;
            $display("FAIL glitch_level: level=%0d required 1", lvl_c);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) strb[k] = ~strb[k];
                ack[k] = ($urandom_range(0, 2) == 0);
            end
            if (!strb[0]) din_a = 8'($urandom);
            if (!strb[1] || $urandom_range(0, 1) == 0) din_b = 8'($urandom);
            if (!strb[2]) din_c = 16'($urandom);
            if (cyc == 300) rst = 1'b1;
            if (cyc == 301) rst = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                logic [15:0] exp_dout;
                exp_dout = (mq[k].size() > 0) ? mq[k][0] : 16'h0;
                checks++;
                if (obs_lvl[k] !== 3'(mq[k].size()) || rdy[k] !== (mq[k].size() > 0)
                    || obs_dout[k] !== exp_dout || ovf[k] !== m_ovf[k]) begin
                    fails++;
                    $display("FAIL random dut%0d cyc %0d: level=%0d rdy=%b dout=%h ovf=%b required %0d/%b/%h/%b",
                             k, cyc, obs_lvl[k], rdy[k], obs_dout[k], ovf[k],
                             mq[k].size(), mq[k].size() > 0, exp_dout, m_ovf[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_reset_midflight();
        test_glitch_wide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
